// File: rtl/rv32im_exu_ctrl.sv
// -----------------------------------------------------------------------------
// rv32im_exu_ctrl
//
// Sequencing controller for the RV32IM execute unit. It accepts one decoded
// instruction at a time, latches the EXU operands, and steps through the
// optional data-memory access or divide before write-back. A memory access
// that returns a bus error, or no response within MEM_TIMEOUT cycles, ends
// in a one-cycle FAULT instead of write-back.
//
// Parameters
//   MEM_TIMEOUT    max MEM cycles with mem_req_o held before a timeout fault
//                  (legal range 2..255)
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset
//   issue_valid_i  decoded instruction presented
//   issue_ready_o  controller can accept an instruction (IDLE only)
//   is_load_i      instruction class flags, sampled only at issue
//   is_store_i
//   is_div_i
//   exu_latch_o    one-cycle operand latch enable, in the accept cycle
//   div_start_o    one-cycle pulse in the first DIV cycle
//   div_done_i     divider finished
//   mem_req_o      data-memory request, held for every MEM cycle
//   mem_we_o       data-memory write enable (store only)
//   mem_ack_i      data-memory acknowledge
//   mem_err_i      data-memory bus error (wins over ack)
//   wb_en_o        register-file write enable (WB, not for stores)
//   pc_en_o        PC update enable (WB only)
//   fault_o        one-cycle fault pulse
//   fault_cause_o  00 none, 01 bus error, 10 timeout; held until next issue
//   busy_o         state is not IDLE
// -----------------------------------------------------------------------------
module rv32im_exu_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_valid_i,
  output logic       issue_ready_o,
  input  logic       is_load_i,
  input  logic       is_store_i,
  input  logic       is_div_i,
  output logic       exu_latch_o,
  output logic       div_start_o,
  input  logic       div_done_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  input  logic       mem_ack_i,
  input  logic       mem_err_i,
  output logic       wb_en_o,
  output logic       pc_en_o,
  output logic       fault_o,
  output logic [1:0] fault_cause_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_DIV,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_BUS     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Counter value seen in the last allowed MEM cycle (counter is 0 in the first).
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  logic       load_q;
  logic       store_q;
  logic       div_q;
  logic [7:0] mem_cnt_q;

  logic accept;
  logic mem_op;
  logic store_op;

  // issue_ready_o is registered and is 1 exactly when the state is IDLE, so the
  // accept decision can use it directly. rst_i gates the accept so the reset
  // value of issue_ready_o never lets an issue through.
  assign accept      = issue_valid_i & issue_ready_o & ~rst_i;
  assign exu_latch_o = accept;

  // Load beats store when both flags are set, so only a pure store writes memory.
  assign mem_op   = load_q | store_q;
  assign store_op = store_q & ~load_q;

  // Every output except exu_latch_o is registered: each transition below
  // assigns the output values that belong to the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      load_q        <= 1'b0;
      store_q       <= 1'b0;
      div_q         <= 1'b0;
      mem_cnt_q     <= 8'd0;
      fault_cause_o <= CAUSE_NONE;
      issue_ready_o <= 1'b1;
      busy_o        <= 1'b0;
      div_start_o   <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      wb_en_o       <= 1'b0;
      pc_en_o       <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by per-state overrides; the last
      // assignment in the block wins, and every register keeps a defined value
      // on every path, so nothing turns into a latch or a race.
      issue_ready_o <= 1'b0;
      busy_o        <= 1'b1;
      div_start_o   <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      wb_en_o       <= 1'b0;
      pc_en_o       <= 1'b0;
      fault_o       <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            load_q        <= is_load_i;
            store_q       <= is_store_i;
            div_q         <= is_div_i;
            fault_cause_o <= CAUSE_NONE;
            state_q       <= S_EXEC;
          end else begin
            issue_ready_o <= 1'b1;
            busy_o        <= 1'b0;
          end
        end

        S_EXEC: begin
          if (mem_op) begin
            mem_cnt_q <= 8'd0;
            mem_req_o <= 1'b1;
            mem_we_o  <= store_op;
            state_q   <= S_MEM;
          end else if (div_q) begin
            div_start_o <= 1'b1;
            state_q     <= S_DIV;
          end else begin
            wb_en_o <= 1'b1;
            pc_en_o <= 1'b1;
            state_q <= S_WB;
          end
        end

        S_MEM: begin
          mem_cnt_q <= mem_cnt_q + 8'd1;
          // Error beats ack; ack beats timeout, so an ack in the last allowed
          // cycle still completes normally.
          if (mem_err_i) begin
            fault_o       <= 1'b1;
            fault_cause_o <= CAUSE_BUS;
            state_q       <= S_FAULT;
          end else if (mem_ack_i) begin
            wb_en_o <= ~store_op;
            pc_en_o <= 1'b1;
            state_q <= S_WB;
          end else if (mem_cnt_q == TIMEOUT_LAST) begin
            fault_o       <= 1'b1;
            fault_cause_o <= CAUSE_TIMEOUT;
            state_q       <= S_FAULT;
          end else begin
            mem_req_o <= 1'b1;
            mem_we_o  <= store_op;
          end
        end

        S_DIV: begin
          // The divider has no timeout; wait as long as it takes.
          if (div_done_i) begin
            wb_en_o <= 1'b1;
            pc_en_o <= 1'b1;
            state_q <= S_WB;
          end
        end

        S_WB, S_FAULT: begin
          issue_ready_o <= 1'b1;
          busy_o        <= 1'b0;
          state_q       <= S_IDLE;
        end

        default: begin
          issue_ready_o <= 1'b1;
          busy_o        <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_exu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32im_exu_ctrl
//
// Scoreboard bench for rv32im_exu_ctrl. Each scenario pushes one entry per
// clock cycle (input stimulus plus the expected output vector) and then
// drains the queue, applying the stimulus after the rising edge and
// comparing the outputs at the falling edge.
//
// Expected vector layout (11 bits):
//   {issue_ready, exu_latch, busy, mem_req, mem_we, div_start,
//    wb_en, pc_en, fault, fault_cause[1:0]}
// -----------------------------------------------------------------------------
module tb_rv32im_exu_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       issue_valid_i;
  logic       issue_ready_o;
  logic       is_load_i;
  logic       is_store_i;
  logic       is_div_i;
  logic       exu_latch_o;
  logic       div_start_o;
  logic       div_done_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       mem_ack_i;
  logic       mem_err_i;
  logic       wb_en_o;
  logic       pc_en_o;
  logic       fault_o;
  logic [1:0] fault_cause_o;
  logic       busy_o;

  rv32im_exu_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .is_load_i     (is_load_i),
    .is_store_i    (is_store_i),
    .is_div_i      (is_div_i),
    .exu_latch_o   (exu_latch_o),
    .div_start_o   (div_start_o),
    .div_done_i    (div_done_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_ack_i     (mem_ack_i),
    .mem_err_i     (mem_err_i),
    .wb_en_o       (wb_en_o),
    .pc_en_o       (pc_en_o),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic valid;
    logic ld;
    logic st;
    logic dv;
    logic done;
    logic ack;
    logic err;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       stim;
    logic [10:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  int vectors    = 0;
  int miscompares = 0;

  // Fault cause the bench expects the DUT to be holding right now.
  logic [1:0] cause = 2'b00;

  localparam stim_t NONE = '0;

  function automatic stim_t mk(input logic valid, ld, st, dv, done, ack, err);
    return '{valid, ld, st, dv, done, ack, err};
  endfunction

  function automatic stim_t issue(input logic ld, st, dv);
    return mk(1'b1, ld, st, dv, 1'b0, 1'b0, 1'b0);
  endfunction

  // Expected vector for an IDLE cycle.
  function automatic logic [10:0] v_idle(input logic latch, input logic [1:0] c);
    return {1'b1, latch, 1'b0, 6'b000000, c};
  endfunction

  // Expected vector for any non-IDLE cycle.
  function automatic logic [10:0] v_busy(input logic req, we, ds, wb, pc, flt,
                                         input logic [1:0] c);
    return {1'b0, 1'b0, 1'b1, req, we, ds, wb, pc, flt, c};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {issue_ready_o, exu_latch_o, busy_o, mem_req_o, mem_we_o, div_start_o,
            wb_en_o, pc_en_o, fault_o, fault_cause_o};
  endfunction

  task automatic push(input string name, input stim_t s, input logic [10:0] e);
    sb_item_t it;
    it.name = name;
    it.stim = s;
    it.exp  = e;
    sb.push_back(it);
  endtask

  // Drive one cycle's inputs and move to the falling edge for sampling.
  task automatic apply(input stim_t s);
    issue_valid_i = s.valid;
    is_load_i     = s.ld;
    is_store_i    = s.st;
    is_div_i      = s.dv;
    div_done_i    = s.done;
    mem_ack_i     = s.ack;
    mem_err_i     = s.err;
    @(negedge clk_i);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b1;
    apply(issue(1'b0, 1'b0, 1'b0));
    next_cycle();
    // Reset values, with an issue presented that must not be accepted.
    vectors++;
    if (obs_vec() !== v_idle(1'b0, 2'b00)) begin
      miscompares++;
      $display("FAIL reset_values: got %b want %b", obs_vec(), v_idle(1'b0, 2'b00));
    end
    next_cycle();
    vectors++;
    if (obs_vec() !== v_idle(1'b0, 2'b00)) begin
      miscompares++;
      $display("FAIL reset_hold_no_issue: got %b want %b", obs_vec(), v_idle(1'b0, 2'b00));
    end
    rst_i = 1'b0;
    apply(NONE);
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu();
    sb_item_t it;
    push("alu_accept", issue(1'b0, 1'b0, 1'b0), v_idle(1'b1, cause));
    cause = 2'b00;
    // A second issue presented during EXEC must be ignored.
    push("alu_exec_ignores_issue", issue(1'b1, 1'b0, 1'b0),
         v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("alu_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    push("alu_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_ack();
    sb_item_t it;
    push("ld_accept", issue(1'b1, 1'b0, 1'b0), v_idle(1'b1, cause));
    cause = 2'b00;
    push("ld_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ld_mem1", NONE, v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ld_mem2", NONE, v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ld_mem3_ack", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
         v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ld_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    push("ld_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_store_bus_error();
    sb_item_t it;
    push("st_accept", issue(1'b0, 1'b1, 1'b0), v_idle(1'b1, cause));
    cause = 2'b00;
    push("st_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    // ack and err together: err wins.
    push("st_mem_ack_err", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1),
         v_busy(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    cause = 2'b01;
    push("st_fault", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cause));
    push("st_idle_cause_held", NONE, v_idle(1'b0, cause));
    push("st_idle_stray_ack", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1),
         v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    sb_item_t it;
    // No response: exactly MEM_TIMEOUT request cycles, then a timeout fault.
    push("to_accept", issue(1'b1, 1'b0, 1'b0), v_idle(1'b1, cause));
    cause = 2'b00;
    push("to_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    for (int i = 0; i < MEM_TIMEOUT; i++)
      push($sformatf("to_mem%0d", i + 1), NONE,
           v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    cause = 2'b10;
    push("to_fault", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cause));
    push("to_idle", NONE, v_idle(1'b0, cause));
    // Ack in the last allowed cycle wins over the timeout.
    push("tl_accept", issue(1'b1, 1'b0, 1'b0), v_idle(1'b1, cause));
    cause = 2'b00;
    push("tl_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    for (int i = 0; i < MEM_TIMEOUT - 1; i++)
      push($sformatf("tl_mem%0d", i + 1), NONE,
           v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("tl_mem_last_ack", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
         v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("tl_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    push("tl_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    sb_item_t it;
    // All flags: load beats store, memory beats div.
    push("pr_all_accept", issue(1'b1, 1'b1, 1'b1), v_idle(1'b1, cause));
    cause = 2'b00;
    push("pr_all_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("pr_all_mem_ack", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
         v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("pr_all_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    push("pr_all_idle", NONE, v_idle(1'b0, cause));
    // Store + div: memory path, store write-back suppressed.
    push("pr_stdv_accept", issue(1'b0, 1'b1, 1'b1), v_idle(1'b1, cause));
    push("pr_stdv_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("pr_stdv_mem_ack", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
         v_busy(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("pr_stdv_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, cause));
    push("pr_stdv_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_div();
    sb_item_t it;
    push("dv_accept", issue(1'b0, 1'b0, 1'b1), v_idle(1'b1, cause));
    cause = 2'b00;
    push("dv_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("dv_start", NONE, v_busy(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cause));
    for (int i = 2; i < 33; i++)
      push($sformatf("dv_wait%0d", i), NONE,
           v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("dv_done", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
         v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("dv_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    push("dv_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    sb_item_t it;
    // issue_valid_i held high: one ALU instruction every 3 cycles.
    for (int n = 0; n < 2; n++) begin
      push($sformatf("b2b_accept%0d", n), issue(1'b0, 1'b0, 1'b0), v_idle(1'b1, cause));
      cause = 2'b00;
      push($sformatf("b2b_exec%0d", n), issue(1'b0, 1'b0, 1'b0),
           v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
      push($sformatf("b2b_wb%0d", n), issue(1'b0, 1'b0, 1'b0),
           v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    end
    push("b2b_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    sb_item_t it;
    // Leave a bus-error cause behind, then reset asynchronously in IDLE.
    push("ar_st_accept", issue(1'b0, 1'b1, 1'b0), v_idle(1'b1, cause));
    cause = 2'b00;
    push("ar_st_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ar_st_mem_err", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
         v_busy(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    cause = 2'b01;
    push("ar_st_fault", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
    #2 rst_i = 1'b1;
    #1;
    cause = 2'b00;
    vectors++;
    if (obs_vec() !== v_idle(1'b0, cause)) begin
      miscompares++;
      $display("FAIL ar_cause_cleared: got %b want %b", obs_vec(), v_idle(1'b0, cause));
    end
    next_cycle();
    rst_i = 1'b0;

    // Load stuck in MEM, reset lands between clock edges.
    push("ar_ld_accept", issue(1'b1, 1'b0, 1'b0), v_idle(1'b1, cause));
    push("ar_ld_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ar_ld_mem1", NONE, v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ar_ld_mem2", NONE, v_busy(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
    vectors++;
    if (mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_mid_mem_before_reset: got mem_req=%b want 1", mem_req_o);
    end
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if (obs_vec() !== v_idle(1'b0, 2'b00)) begin
      miscompares++;
      $display("FAIL ar_mid_mem_reset: got %b want %b", obs_vec(), v_idle(1'b0, 2'b00));
    end
    next_cycle();
    rst_i = 1'b0;

    // Normal start on the first edge after release.
    push("ar_restart_accept", issue(1'b0, 1'b0, 1'b0), v_idle(1'b1, cause));
    push("ar_restart_exec", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cause));
    push("ar_restart_wb", NONE, v_busy(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cause));
    push("ar_restart_idle", NONE, v_idle(1'b0, cause));
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it.stim);
      vectors++;
      if (obs_vec() !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, obs_vec(), it.exp);
      end
      next_cycle();
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_alu();
    test_load_ack();
    test_store_bus_error();
    test_timeout();
    test_priority();
    test_div();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32im_exu_ctrl.md
RV32IM_EXU_CTRL -- requirements
Module: rv32im_exu_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of cycles mem_req_o is held in MEM before a timeout fault (legal range 2..255).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port issue_valid_i, input, 1, decoded instruction presented to the EXU.
REQ-005 SHALL have port issue_ready_o, output, 1, controller can accept an instruction.
REQ-006 SHALL have ports is_load_i, is_store_i, is_div_i, input, 1 each, instruction class flags, sampled only at issue.
REQ-007 SHALL have port exu_latch_o, output, 1, one-cycle enable that latches EXU operands.
REQ-008 SHALL have ports div_start_o, output, 1, and div_done_i, input, 1, the divider handshake.
REQ-009 SHALL have ports mem_req_o, output, 1; mem_we_o, output, 1; mem_ack_i, input, 1; mem_err_i, input, 1, the data-memory handshake.
REQ-010 SHALL have ports wb_en_o, output, 1, and pc_en_o, output, 1, the register-file write and PC update enables.
REQ-011 SHALL have ports fault_o, output, 1, and fault_cause_o, output, 2, the fault pulse and cause (00 none, 01 bus error, 10 timeout).
REQ-012 SHALL have port busy_o, output, 1, asserted whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, EXEC, MEM, DIV, WB and FAULT.
REQ-014 SHALL drive issue_ready_o high only in IDLE; an issue is accepted on a cycle with issue_valid_i=1 and issue_ready_o=1.
REQ-015 SHALL ignore issue_valid_i outside IDLE.
REQ-016 SHALL, on acceptance, register the class flags, pulse exu_latch_o in that same cycle, and enter EXEC.
REQ-017 SHALL make EXEC last exactly one cycle, then go to MEM if load or store, else to DIV if is_div, else to WB.
REQ-018 SHALL give load priority over store and give memory priority over div when several flags are set.
REQ-019 SHALL pulse div_start_o for exactly the first DIV cycle, then wait in DIV with no timeout until div_done_i=1, then go to WB.
REQ-020 SHALL hold mem_req_o=1 in every MEM cycle, with mem_we_o=1 only for a store; both SHALL be 0 outside MEM.
REQ-021 SHALL, in MEM, go to FAULT with cause 01 on mem_err_i; otherwise go to WB on mem_ack_i.
REQ-022 SHALL let mem_err_i win when mem_err_i and mem_ack_i arrive together.
REQ-023 SHALL clear a timeout counter on MEM entry and increment it every MEM cycle.
REQ-024 SHALL go to FAULT with cause 10 after MEM_TIMEOUT MEM cycles without ack or err; an ack in the final allowed cycle SHALL win.
REQ-025 SHALL make WB last one cycle with pc_en_o=1 and wb_en_o=1 except for a store (wb_en_o=0), then return to IDLE.
REQ-026 SHALL make FAULT last one cycle with fault_o=1, pc_en_o=0 and wb_en_o=0, then return to IDLE.
REQ-027 SHALL hold fault_cause_o from FAULT entry until the next accepted issue, which clears it to 00.
REQ-028 SHALL meet these latencies for an issue accepted in cycle T: ALU op has EXEC at T+1 and WB at T+2, giving at most one instruction per 3 cycles; load/store has mem_req_o from T+2, and an ack sampled in cycle A gives WB in A+1.

Reset
REQ-029 SHALL, while rst_i=1, immediately force IDLE and hold it regardless of clock, including mid-MEM and mid-DIV.
REQ-030 SHALL reset the class flags, counter and fault_cause_o to 0.
REQ-031 SHALL reset the outputs to: issue_ready_o=1, busy_o=0, all other outputs 0.
REQ-032 SHALL accept no issue while rst_i=1.
REQ-033 SHALL start normally from IDLE on the first edge after rst_i deasserts.

Verification
REQ-034 SHALL cover an ALU issue (all flags 0) at cycle 0 -> exu_latch_o high at cycle 0, wb_en_o=pc_en_o=1 at cycle 2, issue_ready_o=1 at cycle 3.
REQ-035 SHALL cover a load with mem_ack_i at the 3rd MEM cycle -> mem_req_o high for 3 cycles with mem_we_o=0, then WB with wb_en_o=1.
REQ-036 SHALL cover a store where mem_ack_i and mem_err_i rise together -> FAULT, fault_o one-cycle pulse, fault_cause_o=01, wb_en_o=0, pc_en_o=0.
REQ-037 SHALL cover a load with no response and MEM_TIMEOUT=16 -> mem_req_o high for exactly 16 cycles, then fault_cause_o=10; repeat with ack on cycle 16 -> WB, no fault.
REQ-038 SHALL cover a div with div_done_i after 33 cycles -> div_start_o single pulse, busy_o held high, then WB.
REQ-039 SHALL cover rst_i asserted asynchronously mid-MEM -> mem_req_o=0 immediately, busy_o=0, issue_ready_o=1, fault_cause_o=00.
